// File: rtl/riscv_pkg.sv
// Shared RV32I core constants used by the fetch front end.
package riscv_pkg;
    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
    localparam int              INST_BYTES       = 4;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; storage resets to RST_VAL so the head reads a known word out of reset.
module fetch_fifo #(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~i_flush & ~o_full;
    assign w_pop   = i_pop & ~i_flush & ~o_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RST_VAL;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: keeps up to DEPTH fetches in flight, buffers returned words with
// their PCs and hands them to decode; a redirect flushes the buffer and kills stale responses.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            inst_req_o,
    output logic [XLEN-1:0] inst_addr_o,
    input  logic            inst_gnt_i,
    input  logic            inst_rvalid_i,
    input  logic [XLEN-1:0] inst_i,
    output logic            out_valid_o,
    output logic [XLEN-1:0] out_inst_o,
    output logic [XLEN-1:0] out_pc_o,
    input  logic            out_ready_i
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = 2 * XLEN;

    logic [XLEN-1:0] r_fetch_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_kill;

    logic [CW-1:0]   w_data_count;
    logic [CW-1:0]   w_tag_count;
    logic            w_data_full;
    logic            w_data_empty;
    logic            w_tag_full;
    logic            w_tag_empty;
    logic [XLEN-1:0] w_tag_pc;
    logic [PW-1:0]   w_head;
    logic            w_space;
    logic            w_issue;
    logic            w_killing;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_inflight_after_resp;

    // Buffered plus outstanding words may never exceed the buffer, so responses always have a slot.
    assign w_space     = ({1'b0, w_data_count} + {1'b0, r_inflight}) < (CW+1)'(DEPTH);
    assign inst_req_o  = ~rst & ~redirect_i & w_space;
    assign inst_addr_o = r_fetch_pc;
    assign w_issue     = inst_req_o & inst_gnt_i;
    assign w_killing   = (r_kill != '0);
    assign w_push      = inst_rvalid_i & ~w_killing & ~redirect_i;
    assign w_pop       = out_valid_o & out_ready_i & ~redirect_i;
    assign w_inflight_after_resp = r_inflight - CW'(inst_rvalid_i);

    assign out_valid_o = ~w_data_empty;
    assign out_inst_o  = w_head[PW-1:XLEN];
    assign out_pc_o    = w_head[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= '0;
            r_kill     <= '0;
        end else if (redirect_i) begin
            r_fetch_pc <= redirect_pc_i & ~XLEN'(INST_BYTES - 1);
            r_inflight <= w_inflight_after_resp;
            r_kill     <= w_inflight_after_resp;
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(INST_BYTES);
            end
            r_inflight <= r_inflight + CW'(w_issue) - CW'(inst_rvalid_i);
            if (inst_rvalid_i && w_killing) begin
                r_kill <= r_kill - CW'(1);
            end
        end
    end

    // Tags are never flushed: killed responses still consume their tag.
    fetch_fifo #(
        .WIDTH   (XLEN),
        .DEPTH   (DEPTH),
        .RST_VAL (RESET_PC)
    ) u_tag_q (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_issue),
        .i_data  (r_fetch_pc),
        .i_pop   (inst_rvalid_i),
        .i_flush (1'b0),
        .o_data  (w_tag_pc),
        .o_count (w_tag_count),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty)
    );

    fetch_fifo #(
        .WIDTH   (PW),
        .DEPTH   (DEPTH),
        .RST_VAL ({NOP_INST, RESET_PC})
    ) u_data_q (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({inst_i, w_tag_pc}),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .o_data  (w_head),
        .o_count (w_data_count),
        .o_full  (w_data_full),
        .o_empty (w_data_empty)
    );

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
        inst_rvalid_i |-> (r_inflight != '0) && !w_tag_empty);
    a_tags_track_inflight: assert property (@(posedge clk) disable iff (rst)
        w_tag_count == r_inflight);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && w_data_full) && !(w_issue && w_tag_full));
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order, fixed-latency instruction memory model.
module tb_fetch_unit;
    logic        clk;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_gnt_i;
    logic        inst_rvalid_i;
    logic [31:0] inst_i;
    logic        out_valid_o;
    logic [31:0] out_inst_o;
    logic [31:0] out_pc_o;
    logic        out_ready_i;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t pend[$];
    int   tick;
    int   lat;
    int   n_issue;

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_req_o    (inst_req_o),
        .inst_addr_o   (inst_addr_o),
        .inst_gnt_i    (inst_gnt_i),
        .inst_rvalid_i (inst_rvalid_i),
        .inst_i        (inst_i),
        .out_valid_o   (out_valid_o),
        .out_inst_o    (out_inst_o),
        .out_pc_o      (out_pc_o),
        .out_ready_i   (out_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: a word issued in cycle T returns in cycle T+lat; the word is the inverted address.
    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
            inst_rvalid_i <= 1'b0;
            inst_i        <= '0;
            n_issue       <= 0;
            tick          <= 0;
        end else begin
            if (inst_req_o && inst_gnt_i) begin
                pend.push_back('{addr: inst_addr_o, due: tick + lat});
                n_issue <= n_issue + 1;
            end
            if (pend.size() != 0 && pend[0].due <= tick + 1) begin
                inst_rvalid_i <= 1'b1;
                inst_i        <= ~pend[0].addr;
                void'(pend.pop_front());
            end else begin
                inst_rvalid_i <= 1'b0;
                inst_i        <= '0;
            end
            tick <= tick + 1;
        end
    end

    task automatic do_reset();
        rst        = 1'b1;
        redirect_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        inst_gnt_i = 1'b1; out_ready_i = 1'b1; lat = 1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_vec++; if (inst_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", inst_req_o); end
        n_vec++; if (inst_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 00000000", inst_addr_o); end
        n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid_o); end
        n_vec++; if (out_inst_o !== 32'h0000_0013) begin n_err++; $display("FAIL reset_inst got %h want 00000013", out_inst_o); end
        n_vec++; if (out_pc_o !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 00000000", out_pc_o); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        lat = 1; out_ready_i = 1'b1;
        do_reset();
        rst = 1'b0;
        #1;
        n_vec++; if (inst_req_o !== 1'b1) begin n_err++; $display("FAIL stream_c0_req got %b want 1", inst_req_o); end
        n_vec++; if (inst_addr_o !== 32'h0) begin n_err++; $display("FAIL stream_c0_addr got %h want 00000000", inst_addr_o); end
        @(negedge clk); #1;
        n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL stream_c1_valid got %b want 0", out_valid_o); end
        n_vec++; if (inst_addr_o !== 32'h4) begin n_err++; $display("FAIL stream_c1_addr got %h want 00000004", inst_addr_o); end
        for (int k = 2; k < 10; k++) begin
            @(negedge clk); #1;
            exp_pc = 32'(4 * (k - 2));
            n_vec++; if (out_valid_o !== 1'b1) begin n_err++; $display("FAIL stream_valid c%0d got %b want 1", k, out_valid_o); end
            n_vec++; if (out_pc_o !== exp_pc) begin n_err++; $display("FAIL stream_pc c%0d got %h want %h", k, out_pc_o, exp_pc); end
            n_vec++; if (out_inst_o !== ~exp_pc) begin n_err++; $display("FAIL stream_inst c%0d got %h want %h", k, out_inst_o, ~exp_pc); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        lat = 1; out_ready_i = 1'b0;
        do_reset();
        rst = 1'b0;
        for (int c = 1; c <= 7; c++) @(negedge clk);
        #1;
        n_vec++; if (n_issue !== 4) begin n_err++; $display("FAIL bp_issues got %0d want 4", n_issue); end
        n_vec++; if (inst_req_o !== 1'b0) begin n_err++; $display("FAIL bp_req got %b want 0", inst_req_o); end
        n_vec++; if (inst_addr_o !== 32'h10) begin n_err++; $display("FAIL bp_addr got %h want 00000010", inst_addr_o); end
        n_vec++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h0) begin n_err++; $display("FAIL bp_head got v=%b pc=%h want v=1 pc=00000000", out_valid_o, out_pc_o); end
        @(negedge clk);
        out_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            exp_pc = 32'(4 * k);
            n_vec++; if (out_valid_o !== 1'b1 || out_pc_o !== exp_pc) begin n_err++; $display("FAIL bp_resume k=%0d got v=%b pc=%h want v=1 pc=%h", k, out_valid_o, out_pc_o, exp_pc); end
        end
    endtask

    task automatic test_redirect_stale();
        lat = 3; out_ready_i = 1'b1;
        do_reset();
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) @(negedge clk);
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100;
        #1;
        n_vec++; if (inst_req_o !== 1'b0) begin n_err++; $display("FAIL stale_req_on_redirect got %b want 0", inst_req_o); end
        @(negedge clk);
        redirect_i = 1'b0;
        #1;
        n_vec++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h100) begin n_err++; $display("FAIL stale_target_req got req=%b addr=%h want req=1 addr=00000100", inst_req_o, inst_addr_o); end
        for (int c = 4; c <= 7; c++) begin
            if (c != 4) begin @(negedge clk); #1; end
            n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL stale_valid c%0d got %b want 0", c, out_valid_o); end
        end
        @(negedge clk); #1;
        n_vec++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h100 || out_inst_o !== ~32'h100) begin n_err++; $display("FAIL stale_first got v=%b pc=%h inst=%h want v=1 pc=00000100 inst=fffffeff", out_valid_o, out_pc_o, out_inst_o); end
        @(negedge clk); #1;
        n_vec++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h104) begin n_err++; $display("FAIL stale_second got v=%b pc=%h want v=1 pc=00000104", out_valid_o, out_pc_o); end
    endtask

    task automatic test_redirect_with_rvalid();
        lat = 3; out_ready_i = 1'b0;
        do_reset();
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) @(negedge clk);
        #1;
        n_vec++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h0) begin n_err++; $display("FAIL rvr_head got v=%b pc=%h want v=1 pc=00000000", out_valid_o, out_pc_o); end
        n_vec++; if (inst_rvalid_i !== 1'b1) begin n_err++; $display("FAIL rvr_rvalid_setup got %b want 1", inst_rvalid_i); end
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200; out_ready_i = 1'b1;
        @(negedge clk);
        redirect_i = 1'b0;
        #1;
        n_vec++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h200) begin n_err++; $display("FAIL rvr_target_req got req=%b addr=%h want req=1 addr=00000200", inst_req_o, inst_addr_o); end
        for (int c = 5; c <= 8; c++) begin
            if (c != 5) begin @(negedge clk); #1; end
            n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL rvr_valid c%0d got %b want 0", c, out_valid_o); end
        end
        @(negedge clk); #1;
        n_vec++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h200 || out_inst_o !== ~32'h200) begin n_err++; $display("FAIL rvr_first got v=%b pc=%h inst=%h want v=1 pc=00000200 inst=fffffdff", out_valid_o, out_pc_o, out_inst_o); end
        @(negedge clk); #1;
        n_vec++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h204) begin n_err++; $display("FAIL rvr_second got v=%b pc=%h want v=1 pc=00000204", out_valid_o, out_pc_o); end
    endtask

    task automatic test_wrap();
        lat = 1; out_ready_i = 1'b1;
        do_reset();
        rst = 1'b0;
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
        @(negedge clk);
        redirect_i = 1'b0;
        #1;
        n_vec++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr0 got req=%b addr=%h want req=1 addr=fffffffc", inst_req_o, inst_addr_o); end
        @(negedge clk); #1;
        n_vec++; if (inst_addr_o !== 32'h0) begin n_err++; $display("FAIL wrap_addr1 got %h want 00000000", inst_addr_o); end
        @(negedge clk); #1;
        n_vec++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'hFFFF_FFFC || out_inst_o !== 32'h3) begin n_err++; $display("FAIL wrap_out0 got v=%b pc=%h inst=%h want v=1 pc=fffffffc inst=00000003", out_valid_o, out_pc_o, out_inst_o); end
        @(negedge clk); #1;
        n_vec++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h0) begin n_err++; $display("FAIL wrap_out1 got v=%b pc=%h want v=1 pc=00000000", out_valid_o, out_pc_o); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_pc;
        lat = 1; out_ready_i = 1'b0;
        do_reset();
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) @(negedge clk);
        #1;
        n_vec++; if (out_valid_o !== 1'b1 || inst_rvalid_i !== 1'b1) begin n_err++; $display("FAIL rmid_setup got v=%b rvalid=%b want v=1 rvalid=1", out_valid_o, inst_rvalid_i); end
        rst = 1'b1;
        @(negedge clk); #1;
        n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b want 0", out_valid_o); end
        n_vec++; if (out_inst_o !== 32'h13 || out_pc_o !== 32'h0) begin n_err++; $display("FAIL rmid_head got inst=%h pc=%h want inst=00000013 pc=00000000", out_inst_o, out_pc_o); end
        rst = 1'b0; out_ready_i = 1'b1;
        #1;
        n_vec++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h0) begin n_err++; $display("FAIL rmid_req got req=%b addr=%h want req=1 addr=00000000", inst_req_o, inst_addr_o); end
        @(negedge clk); #1;
        n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_c1_valid got %b want 0", out_valid_o); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            exp_pc = 32'(4 * k);
            n_vec++; if (out_valid_o !== 1'b1 || out_pc_o !== exp_pc) begin n_err++; $display("FAIL rmid_stream k=%0d got v=%b pc=%h want v=1 pc=%h", k, out_valid_o, out_pc_o, exp_pc); end
        end
    endtask

    initial begin
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        inst_gnt_i = 1'b1; out_ready_i = 1'b1; lat = 1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_stale();
        test_redirect_with_rvalid();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1, "watchdog");
    end
endmodule
